// File: rtl/dcmac_pkg.sv
// Shared definitions for the DCMAC RX segment merger: segment geometry,
// tuser field positions and the packet state encoding.
package dcmac_pkg;

    localparam int unsigned SEG_W     = 128;
    localparam int unsigned SEG_N     = 4;
    localparam int unsigned SEG_BYTES = SEG_W / 8;
    localparam int unsigned SEG_IDX_W = $clog2(SEG_N);
    localparam int unsigned TUSER_W   = 5;
    localparam int unsigned MTY_LSB   = 0;
    localparam int unsigned MTY_MSB   = 3;
    localparam int unsigned ERR_BIT   = 4;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DISCARD
    } rx_state_t;

endpackage

// File: rtl/dcmac_mty_to_keep.sv
// Per-segment byte-keep generator: full below the eop segment, mty-trimmed
// at the eop segment, empty above it.
module dcmac_mty_to_keep
    import dcmac_pkg::*;
(
    input  logic [MTY_MSB:MTY_LSB] mty,
    input  logic                   below_eop,
    input  logic                   at_eop,
    output logic [SEG_BYTES-1:0]   keep
);

    always_comb begin
        keep = '0;
        if (below_eop) begin
            keep = '1;
        end else if (at_eop) begin
            keep = {SEG_BYTES{1'b1}} >> mty;
        end
    end

endmodule

// File: rtl/dcmac_rx_merger.sv
// Joins four DCMAC RX segment streams into one 512-bit AXI stream with
// byte-accurate tkeep, a sticky packet error flag and packet statistics.
module dcmac_rx_merger
    import dcmac_pkg::*;
#(
    parameter int unsigned MAX_PACKET_SIZE = 16384
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [127:0] axis0_in_tdata,
    input  logic [4:0]   axis0_in_tuser,
    input  logic         axis0_in_tlast,
    input  logic         axis0_in_tvalid,
    output logic         axis0_in_tready,
    input  logic [127:0] axis1_in_tdata,
    input  logic [4:0]   axis1_in_tuser,
    input  logic         axis1_in_tlast,
    input  logic         axis1_in_tvalid,
    output logic         axis1_in_tready,
    input  logic [127:0] axis2_in_tdata,
    input  logic [4:0]   axis2_in_tuser,
    input  logic         axis2_in_tlast,
    input  logic         axis2_in_tvalid,
    output logic         axis2_in_tready,
    input  logic [127:0] axis3_in_tdata,
    input  logic [4:0]   axis3_in_tuser,
    input  logic         axis3_in_tlast,
    input  logic         axis3_in_tvalid,
    output logic         axis3_in_tready,
    output logic [511:0] axis_out_tdata,
    output logic [63:0]  axis_out_tkeep,
    output logic         axis_out_tuser,
    output logic         axis_out_tlast,
    output logic         axis_out_tvalid,
    input  logic         axis_out_tready,
    output logic [31:0]  pkt_count,
    output logic [31:0]  err_count
);

    localparam int unsigned MAX_BEATS = MAX_PACKET_SIZE / 64;
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

    logic [SEG_N-1:0][SEG_W-1:0]     seg_data;
    logic [SEG_N-1:0][TUSER_W-1:0]   seg_user;
    logic [SEG_N-1:0]                seg_last;
    logic [SEG_N-1:0]                seg_valid;
    logic [SEG_N-1:0][SEG_W-1:0]     beat_data;
    logic [SEG_N-1:0][SEG_BYTES-1:0] beat_keep;
    logic [SEG_N-1:0]                seg_below;
    logic [SEG_N-1:0]                seg_at;
    logic [SEG_N-1:0]                seg_err;

    logic                 all_valid;
    logic                 eop_found;
    logic [SEG_IDX_W-1:0] eop_idx;
    logic                 beat_err;
    logic                 can_load;
    logic                 at_cap;
    logic                 in_ready;
    logic                 emit;
    logic                 truncate;
    logic                 last_nxt;
    logic                 user_nxt;

    rx_state_t            state, state_nxt;
    logic                 err_acc;
    logic [CNT_W-1:0]     beat_cnt;

    assign seg_data  = {axis3_in_tdata, axis2_in_tdata, axis1_in_tdata, axis0_in_tdata};
    assign seg_user  = {axis3_in_tuser, axis2_in_tuser, axis1_in_tuser, axis0_in_tuser};
    assign seg_last  = {axis3_in_tlast, axis2_in_tlast, axis1_in_tlast, axis0_in_tlast};
    assign seg_valid = {axis3_in_tvalid, axis2_in_tvalid, axis1_in_tvalid, axis0_in_tvalid};

    assign all_valid = &seg_valid;
    assign eop_found = |seg_last;

    // Scan from the top so the lowest segment with tlast wins.
    always_comb begin
        eop_idx = '0;
        for (int unsigned i = 0; i < SEG_N; i++) begin
            if (seg_last[SEG_N-1-i]) begin
                eop_idx = SEG_IDX_W'(SEG_N-1-i);
            end
        end
    end

    for (genvar n = 0; n < SEG_N; n++) begin : g_seg
        assign seg_below[n] = !eop_found || (SEG_IDX_W'(n) < eop_idx);
        assign seg_at[n]    = eop_found && (SEG_IDX_W'(n) == eop_idx);
        assign beat_data[n] = (seg_below[n] || seg_at[n]) ? seg_data[n] : '0;
        assign seg_err[n]   = (seg_below[n] || seg_at[n]) && seg_user[n][ERR_BIT];

        dcmac_mty_to_keep u_keep (
            .mty       (seg_user[n][MTY_MSB:MTY_LSB]),
            .below_eop (seg_below[n]),
            .at_eop    (seg_at[n]),
            .keep      (beat_keep[n])
        );
    end

    assign beat_err = |seg_err;
    assign can_load = !axis_out_tvalid || axis_out_tready;
    assign at_cap   = (beat_cnt == CNT_W'(MAX_BEATS - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        emit      = 1'b0;
        truncate  = 1'b0;
        case (state)
            IDLE, PASS: begin
                in_ready = all_valid && can_load;
                if (in_ready) begin
                    emit = 1'b1;
                    if (eop_found) begin
                        state_nxt = IDLE;
                    end else if (at_cap) begin
                        truncate  = 1'b1;
                        state_nxt = DISCARD;
                    end else begin
                        state_nxt = PASS;
                    end
                end
            end
            DISCARD: begin
                // Dropping does not touch the output register, so the sink is irrelevant.
                in_ready = all_valid;
                if (all_valid && eop_found) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last_nxt = eop_found || truncate;
    assign user_nxt = last_nxt && (err_acc || beat_err || truncate);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            err_acc         <= 1'b0;
            beat_cnt        <= '0;
            axis_out_tvalid <= 1'b0;
            axis_out_tdata  <= '0;
            axis_out_tkeep  <= '0;
            axis_out_tlast  <= 1'b0;
            axis_out_tuser  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (emit) begin
                if (last_nxt) begin
                    err_acc  <= 1'b0;
                    beat_cnt <= '0;
                end else begin
                    err_acc  <= err_acc | beat_err;
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
            if (can_load) begin
                axis_out_tvalid <= emit;
                if (emit) begin
                    axis_out_tdata <= beat_data;
                    axis_out_tkeep <= beat_keep;
                    axis_out_tlast <= last_nxt;
                    axis_out_tuser <= user_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_count <= '0;
            err_count <= '0;
        end else if (axis_out_tvalid && axis_out_tready && axis_out_tlast) begin
            pkt_count <= pkt_count + 32'd1;
            if (axis_out_tuser) begin
                err_count <= err_count + 32'd1;
            end
        end
    end

    assign axis0_in_tready = in_ready;
    assign axis1_in_tready = in_ready;
    assign axis2_in_tready = in_ready;
    assign axis3_in_tready = in_ready;

endmodule

// File: tb/tb_dcmac_rx_merger.sv
// Scoreboard bench for dcmac_rx_merger: packets are built at byte level,
// expected output beats are queued at stimulus time and checked by a monitor.
module tb_dcmac_rx_merger;

    localparam int unsigned MPS = 256;
    localparam int unsigned MB  = MPS / 64;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [127:0] in_tdata  [4];
    logic [4:0]   in_tuser  [4];
    logic         in_tlast  [4];
    logic         in_tvalid [4];
    logic         in_tready [4];
    logic [511:0] axis_out_tdata;
    logic [63:0]  axis_out_tkeep;
    logic         axis_out_tuser;
    logic         axis_out_tlast;
    logic         axis_out_tvalid;
    logic         axis_out_tready;
    logic [31:0]  pkt_count;
    logic [31:0]  err_count;

    always #5 clk = ~clk;

    dcmac_rx_merger #(.MAX_PACKET_SIZE(MPS)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .axis0_in_tdata  (in_tdata[0]),
        .axis0_in_tuser  (in_tuser[0]),
        .axis0_in_tlast  (in_tlast[0]),
        .axis0_in_tvalid (in_tvalid[0]),
        .axis0_in_tready (in_tready[0]),
        .axis1_in_tdata  (in_tdata[1]),
        .axis1_in_tuser  (in_tuser[1]),
        .axis1_in_tlast  (in_tlast[1]),
        .axis1_in_tvalid (in_tvalid[1]),
        .axis1_in_tready (in_tready[1]),
        .axis2_in_tdata  (in_tdata[2]),
        .axis2_in_tuser  (in_tuser[2]),
        .axis2_in_tlast  (in_tlast[2]),
        .axis2_in_tvalid (in_tvalid[2]),
        .axis2_in_tready (in_tready[2]),
        .axis3_in_tdata  (in_tdata[3]),
        .axis3_in_tuser  (in_tuser[3]),
        .axis3_in_tlast  (in_tlast[3]),
        .axis3_in_tvalid (in_tvalid[3]),
        .axis3_in_tready (in_tready[3]),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tkeep  (axis_out_tkeep),
        .axis_out_tuser  (axis_out_tuser),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .pkt_count       (pkt_count),
        .err_count       (err_count)
    );

    typedef struct {
        logic [3:0][127:0] d;
        logic [3:0][4:0]   u;
        logic [3:0]        l;
    } in_beat_t;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic         u;
    } out_beat_t;

    in_beat_t  in_q  [$];
    out_beat_t exp_q [$];

    int errors = 0;
    int checks = 0;
    int exp_pkt = 0;
    int exp_err = 0;
    bit mon_en = 1'b0;
    int tr_mode = 0;     // 0: sink always ready, 1: random, 2: stall window
    int vprob = 100;     // percent chance a waiting segment raises tvalid
    int hold_seg = -1;
    int hold_cyc = 0;

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sink_ready(int cyc);
        if (tr_mode == 1) return ($urandom_range(0, 3) != 0);
        if (tr_mode == 2) return !(cyc >= 2 && cyc <= 6);
        return 1'b1;
    endfunction

    // Build one packet of len bytes; expected beats follow the byte-level rules.
    task automatic build_packet(int len, int err_pct, int err_b, int err_s, bit push_exp);
        int nb;
        bit acc;
        bit last;
        int r;
        int k;
        in_beat_t  ib;
        out_beat_t ob;
        nb  = (len + 63) / 64;
        acc = 1'b0;
        for (int b = 0; b < nb; b++) begin
            last = (b == nb - 1);
            r    = last ? len - 64 * b : 64;
            k    = last ? (r - 1) / 16 : 3;
            ob.d = '0;
            for (int n = 0; n < 4; n++) begin
                ib.d[n]       = {$urandom, $urandom, $urandom, $urandom};
                ib.u[n][3:0]  = 4'($urandom);
                ib.u[n][4]    = (err_pct > 0 && $urandom_range(0, 99) < err_pct) ||
                                (b == err_b && n == err_s);
                ib.l[n]       = (last && n > k) ? 1'($urandom) : 1'b0;
                if (last && n == k) begin
                    ib.l[n]      = 1'b1;
                    ib.u[n][3:0] = 4'(16 * (k + 1) - r);
                end
                if (n <= k && ib.u[n][4]) acc = 1'b1;
                if (n <= k) ob.d[128*n +: 128] = ib.d[n];
            end
            ob.k = (r == 64) ? '1 : ((64'd1 << r) - 64'd1);
            ob.l = last;
            ob.u = acc;
            if (nb > MB && b == MB - 1) begin
                ob.l = 1'b1;
                ob.u = 1'b1;
            end
            in_q.push_back(ib);
            if (push_exp && b < MB) exp_q.push_back(ob);
        end
    endtask

    task automatic idle_inputs();
        for (int n = 0; n < 4; n++) begin
            in_tvalid[n] = 1'b0;
            in_tlast[n]  = 1'b0;
            in_tuser[n]  = '0;
            in_tdata[n]  = '0;
        end
    endtask

    task automatic run_stream(int budget);
        logic [3:0] vm;
        int cyc;
        int wcnt;
        vm   = '0;
        cyc  = 0;
        wcnt = 0;
        while (in_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            axis_out_tready = sink_ready(cyc);
            cyc++;
            for (int n = 0; n < 4; n++) begin
                if (!vm[n] && (n != hold_seg || wcnt >= hold_cyc) &&
                    $urandom_range(1, 100) <= vprob)
                    vm[n] = 1'b1;
                in_tvalid[n] = vm[n];
                in_tdata[n]  = in_q[0].d[n];
                in_tuser[n]  = in_q[0].u[n];
                in_tlast[n]  = in_q[0].l[n];
            end
            wcnt++;
            #4;
            if (vm != 4'hF) begin
                check("tready_partial", {in_tready[0], in_tready[1], in_tready[2], in_tready[3]}, 4'h0);
            end else if (tr_mode == 2 && axis_out_tvalid && !axis_out_tready) begin
                check("tready_stall", in_tready[0], 1'b0);
            end
            if (in_tready[0] && vm == 4'hF) begin
                void'(in_q.pop_front());
                vm   = '0;
                wcnt = 0;
                hold_seg = -1;
            end
        end
        @(negedge clk);
        idle_inputs();
        if (in_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL input_timeout: got %0d beats pending expected 0", in_q.size());
            in_q.delete();
        end
    endtask

    task automatic drain(int budget);
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            axis_out_tready = (tr_mode == 1) ? sink_ready(cyc) : 1'b1;
            cyc++;
        end
        repeat (2) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL output_timeout: got %0d beats missing expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send(int len, int err_b, int err_s, int budget);
        build_packet(len, 0, err_b, err_s, 1'b1);
        run_stream(budget);
        drain(budget);
    endtask

    // Monitor: checks each output handshake against the scoreboard head.
    initial begin
        out_beat_t e;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en && axis_out_tvalid && axis_out_tready) begin
                check("pkt_count", pkt_count, 32'(exp_pkt));
                check("err_count", err_count, 32'(exp_err));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got tdata %0h expected none", axis_out_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", axis_out_tdata, e.d);
                    check("tkeep", axis_out_tkeep, e.k);
                    check("tlast", axis_out_tlast, e.l);
                    if (e.l) begin
                        check("tuser", axis_out_tuser, e.u);
                        exp_pkt++;
                        if (e.u) exp_err++;
                    end
                end
            end
        end
    end

    task automatic check_reset_state();
        check("rst_tvalid", axis_out_tvalid, 1'b0);
        check("rst_tdata", axis_out_tdata, '0);
        check("rst_tkeep", axis_out_tkeep, '0);
        check("rst_tlast", axis_out_tlast, 1'b0);
        check("rst_tuser", axis_out_tuser, 1'b0);
        check("rst_tready", in_tready[0], 1'b0);
        check("rst_pkt_count", pkt_count, '0);
        check("rst_err_count", err_count, '0);
    endtask

    initial begin
        int len;
        idle_inputs();
        axis_out_tready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state();
        resetn = 1'b1;

        // Leave a packet half-finished (beat count at cap, error latched), then reset.
        @(negedge clk);
        build_packet(64, 0, -1, -1, 1'b0);
        build_packet(400, 0, 0, 0, 1'b0);
        while (in_q.size() > 4) void'(in_q.pop_back());
        run_stream(200);
        repeat (3) @(negedge clk);
        axis_out_tready = 1'b0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        resetn = 1'b1;
        mon_en = 1'b1;

        send(100, -1, -1, 200);          // eop on seg 2, mty 12
        send(64, -1, -1, 200);           // single full beat
        hold_seg = 2;
        hold_cyc = 3;
        send(128, -1, -1, 200);          // seg 2 skewed late
        hold_cyc = 0;
        tr_mode = 2;
        send(192, -1, -1, 200);          // sink stall mid-packet
        tr_mode = 0;
        send(192, 0, 1, 200);            // err on seg 1 of first beat
        send(384, -1, -1, 200);          // truncated at 4 beats
        send(64, -1, -1, 200);
        send(256, -1, -1, 200);          // eop exactly at cap
        send(257, -1, -1, 200);
        send(1, -1, -1, 200);

        tr_mode = 1;
        vprob = 75;
        for (int i = 0; i < 300; i++) begin
            len = $urandom_range(1, 384);
            build_packet(len, 5, -1, -1, 1'b1);
        end
        run_stream(20000);
        drain(5000);

        check("final_pkt_count", pkt_count, 32'(exp_pkt));
        check("final_err_count", err_count, 32'(exp_err));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
